bus_arbiter: RTL



---
 rtl/bus_arbiter_if.sv | 22 ++
 rtl/bus_arbiter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_if.sv
// Shared-bus arbitration signals between requesters (master side) and the arbiter (slave side).
interface bus_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] last;
    logic               err_clr;
    logic [NUM_REQ-1:0] grant;
    logic               bus_oe_n;
    logic               timeout_err;
    logic [2:0]         owner;

    modport master (
        output req, last, err_clr,
        input  grant, bus_oe_n, timeout_err, owner
    );

    modport slave (
        input  req, last, err_clr,
        output grant, bus_oe_n, timeout_err, owner
    );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for a shared data bus with turnaround gap and hold timeout.
module bus_arbiter #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned TURN_CYC = 1,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    bus_arbiter_if.slave bus
);
    localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned TURN_W = 3;
    localparam int unsigned OWN_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [NUM_REQ-1:0]  r_grant;
    logic [NUM_REQ-1:0]  w_grant_nxt;
    logic                r_bus_oe_n;
    logic                w_bus_oe_n_nxt;
    logic                r_timeout_err;
    logic                w_timeout_err_nxt;
    logic [IDX_W-1:0]    r_owner;
    logic [IDX_W-1:0]    w_owner_nxt;
    logic [CNT_W-1:0]    r_hold_cnt;
    logic [CNT_W-1:0]    w_hold_cnt_nxt;
    logic [TURN_W-1:0]   r_turn_cnt;
    logic [TURN_W-1:0]   w_turn_cnt_nxt;

    logic [IDX_W-1:0]    w_winner;
    logic                w_any_req;
    logic                w_release;
    logic                w_timeout;
    logic                w_turn_done;

    // Round-robin pick: smallest distance above the current owner, wrapping around.
    always_comb begin
        int unsigned v_dist;
        int unsigned v_best;
        w_winner = r_owner;
        v_best   = NUM_REQ;
        v_dist   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            v_dist = (32'(i) + NUM_REQ - 32'(r_owner) - 32'd1) % NUM_REQ;
            if (bus.req[i] && (v_dist < v_best)) begin
                v_best   = v_dist;
                w_winner = IDX_W'(i);
            end
        end
    end

    // Release/timeout conditions look only at the current owner's bits.
    always_comb begin
        w_any_req   = |bus.req;
        w_release   = bus.last[r_owner] | ~bus.req[r_owner];
        w_timeout   = (r_hold_cnt == CNT_W'(TIMEOUT)) & ~w_release;
        w_turn_done = (r_turn_cnt == TURN_W'(TURN_CYC));
    end

    // State register; async reset drops straight to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (w_release || w_timeout) begin
                    w_state_nxt = (TURN_CYC != 0) ? ST_TURN : ST_IDLE;
                end
            end
            ST_TURN: begin
                if (w_turn_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs and counters.
    always_comb begin
        w_grant_nxt       = r_grant;
        w_bus_oe_n_nxt    = r_bus_oe_n;
        w_owner_nxt       = r_owner;
        w_hold_cnt_nxt    = r_hold_cnt;
        w_turn_cnt_nxt    = r_turn_cnt;
        w_timeout_err_nxt = bus.err_clr ? 1'b0 : r_timeout_err;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_grant_nxt    = NUM_REQ'(1) << w_winner;
                    w_bus_oe_n_nxt = 1'b0;
                    w_owner_nxt    = w_winner;
                    w_hold_cnt_nxt = CNT_W'(1);
                end else begin
                    w_grant_nxt    = '0;
                    w_bus_oe_n_nxt = 1'b1;
                end
            end
            ST_GRANT: begin
                if (w_release || w_timeout) begin
                    w_grant_nxt    = '0;
                    w_bus_oe_n_nxt = 1'b1;
                    w_hold_cnt_nxt = '0;
                    w_turn_cnt_nxt = (TURN_CYC != 0) ? TURN_W'(1) : '0;
                    if (w_timeout) begin
                        w_timeout_err_nxt = 1'b1;
                    end
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt + CNT_W'(1);
                end
            end
            ST_TURN: begin
                w_grant_nxt    = '0;
                w_bus_oe_n_nxt = 1'b1;
                if (w_turn_done) begin
                    w_turn_cnt_nxt = '0;
                end else begin
                    w_turn_cnt_nxt = r_turn_cnt + TURN_W'(1);
                end
            end
            default: begin
                w_grant_nxt    = '0;
                w_bus_oe_n_nxt = 1'b1;
                w_hold_cnt_nxt = '0;
                w_turn_cnt_nxt = '0;
            end
        endcase
    end

    // Output and counter registers; owner resets to the top index so requester 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant       <= '0;
            r_bus_oe_n    <= 1'b1;
            r_timeout_err <= 1'b0;
            r_owner       <= IDX_W'(NUM_REQ - 1);
            r_hold_cnt    <= '0;
            r_turn_cnt    <= '0;
        end else begin
            r_grant       <= w_grant_nxt;
            r_bus_oe_n    <= w_bus_oe_n_nxt;
            r_timeout_err <= w_timeout_err_nxt;
            r_owner       <= w_owner_nxt;
            r_hold_cnt    <= w_hold_cnt_nxt;
            r_turn_cnt    <= w_turn_cnt_nxt;
        end
    end

    assign bus.grant       = r_grant;
    assign bus.bus_oe_n    = r_bus_oe_n;
    assign bus.timeout_err = r_timeout_err;
    assign bus.owner       = OWN_W'(r_owner);

endmodule
